// File: rtl/sram_bist_monitor.sv
// Passive SRAM BIST result logger: re-times observed reads through the two-cycle
// SRAM latency, checks them against the address pattern and keeps mismatch statistics.
module sram_bist_monitor #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              BIST_start,
  input  logic              BIST_finish,
  input  logic [ADDR_W-1:0] SRAM_address,
  input  logic              SRAM_we_n,
  input  logic [DATA_W-1:0] SRAM_read_data,
  output logic              MON_busy,
  output logic              MON_done,
  output logic              MON_fail,
  output logic [CNT_W-1:0]  MON_mismatch_count,
  output logic [19:0]       MON_read_count,
  output logic [ADDR_W-1:0] MON_first_addr,
  output logic [DATA_W-1:0] MON_first_data,
  output logic [ADDR_W-1:0] MON_last_addr
);

  // state   | meaning
  // M_IDLE  | not checking; results of the last complete run held
  // M_ARMED | engine running; every non-finish read cycle enters the pipeline
  // M_DRAIN | finish seen; waiting for in-flight reads to be compared
  typedef enum logic [1:0] {M_IDLE, M_ARMED, M_DRAIN} state_t;

  state_t            state;
  logic              start_buf;
  logic              arm;
  logic              issue;
  logic [1:0]        armed_cnt;
  logic              v1;
  logic              v2;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic              mismatch;
  logic              drain_done;

  assign arm        = BIST_start & ~start_buf;
  assign issue      = (state == M_ARMED) & SRAM_we_n & ~BIST_finish;
  assign mismatch   = v2 & (SRAM_read_data != a2[DATA_W-1:0]);
  assign drain_done = (state == M_DRAIN) & ~v1 & ~v2;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      start_buf <= 1'b0;
      state     <= M_IDLE;
      armed_cnt <= 2'd0;
      MON_busy  <= 1'b0;
      MON_done  <= 1'b0;
    end else begin
      start_buf <= BIST_start;
      if (arm) begin
        state     <= M_ARMED;
        armed_cnt <= 2'd0;
        MON_busy  <= 1'b1;
        MON_done  <= 1'b0;
      end else begin
        case (state)
          M_ARMED: begin
            if (armed_cnt != 2'd2)
              armed_cnt <= armed_cnt + 2'd1;
            // finish is still high from the previous run for the first armed cycles
            if (BIST_finish && armed_cnt == 2'd2)
              state <= M_DRAIN;
          end
          M_DRAIN: begin
            if (drain_done) begin
              state    <= M_IDLE;
              MON_busy <= 1'b0;
              MON_done <= 1'b1;
            end
          end
          default: state <= M_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
    end else if (arm) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
    end else begin
      v1 <= issue;
      a1 <= SRAM_address;
      v2 <= v1;
      a2 <= a1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      MON_fail           <= 1'b0;
      MON_mismatch_count <= '0;
      MON_read_count     <= '0;
      MON_first_addr     <= '0;
      MON_first_data     <= '0;
      MON_last_addr      <= '0;
    end else if (arm) begin
      MON_fail           <= 1'b0;
      MON_mismatch_count <= '0;
      MON_read_count     <= '0;
      MON_first_addr     <= '0;
      MON_first_data     <= '0;
      MON_last_addr      <= '0;
    end else if (v2) begin
      if (MON_read_count != 20'hFFFFF)
        MON_read_count <= MON_read_count + 20'd1;
      if (mismatch) begin
        if (MON_mismatch_count != {CNT_W{1'b1}})
          MON_mismatch_count <= MON_mismatch_count + {{(CNT_W-1){1'b0}}, 1'b1};
        MON_last_addr <= a2;
        if (!MON_fail) begin
          MON_fail       <= 1'b1;
          MON_first_addr <= a2;
          MON_first_data <= SRAM_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bist_monitor.sv
// Bench for sram_bist_monitor: directed BIST runs against a 2-cycle SRAM model
// with injectable faults; end-of-run results are checked from a scoreboard queue.
module tb_sram_bist_monitor;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        BIST_start = 1'b0;
  logic        BIST_finish = 1'b1;
  logic [17:0] SRAM_address = '0;
  logic        SRAM_we_n = 1'b1;
  logic [15:0] SRAM_read_data = '0;

  logic        busy, done, fail;
  logic [15:0] mm_cnt;
  logic [19:0] rd_cnt;
  logic [17:0] first_addr, last_addr;
  logic [15:0] first_data;

  logic        s_busy, s_done, s_fail;
  logic [3:0]  s_mm_cnt;
  logic [19:0] s_rd_cnt;
  logic [17:0] s_first_addr, s_last_addr;
  logic [15:0] s_first_data;

  always #5 Clock = ~Clock;

  sram_bist_monitor dut (
    .Clock(Clock), .Resetn(Resetn), .BIST_start(BIST_start), .BIST_finish(BIST_finish),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .MON_busy(busy), .MON_done(done), .MON_fail(fail), .MON_mismatch_count(mm_cnt),
    .MON_read_count(rd_cnt), .MON_first_addr(first_addr), .MON_first_data(first_data),
    .MON_last_addr(last_addr)
  );

  sram_bist_monitor #(.CNT_W(4)) dut_sat (
    .Clock(Clock), .Resetn(Resetn), .BIST_start(BIST_start), .BIST_finish(BIST_finish),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .MON_busy(s_busy), .MON_done(s_done), .MON_fail(s_fail), .MON_mismatch_count(s_mm_cnt),
    .MON_read_count(s_rd_cnt), .MON_first_addr(s_first_addr), .MON_first_data(s_first_data),
    .MON_last_addr(s_last_addr)
  );

  // SRAM model: pattern memory with fault injection, data two edges after address
  logic        stuck_en = 0, fa_en = 0, fb_en = 0, fault_all = 0;
  logic [17:0] fa = '0, fb = '0;
  logic [17:0] q1 = '0;

  function automatic logic [15:0] sram_word(input logic [17:0] a);
    logic [15:0] w;
    w = a[15:0];
    if (fault_all) w = ~w;
    else if (stuck_en && a == 18'h00010) w = w | 16'h0008;
    else if ((fa_en && a == fa) || (fb_en && a == fb)) w = w ^ 16'h0001;
    return w;
  endfunction

  always @(posedge Clock) begin
    q1 <= SRAM_address;
    SRAM_read_data <= sram_word(q1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [19:0] rc;
    logic [15:0] mm;
    logic        fl;
    logic [17:0] fad;
    logic [15:0] fdt;
    logic [17:0] lad;
  } exp_t;

  exp_t sb[$];

  task automatic expect_run(input logic [19:0] rc, input logic [15:0] mm, input logic fl,
                            input logic [17:0] fad, input logic [15:0] fdt, input logic [17:0] lad);
    exp_t e;
    e.rc = rc; e.mm = mm; e.fl = fl; e.fad = fad; e.fdt = fdt; e.lad = lad;
    sb.push_back(e);
  endtask

  // Monitor: compares results whenever the DUT raises MON_done
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge Clock);
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done rose with no run pending (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("read_count", 32'(rd_cnt), 32'(e.rc));
          check("mismatch_count", 32'(mm_cnt), 32'(e.mm));
          check("fail", 32'(fail), 32'(e.fl));
          check("first_addr", 32'(first_addr), 32'(e.fad));
          check("first_data", 32'(first_data), 32'(e.fdt));
          check("last_addr", 32'(last_addr), 32'(e.lad));
          check("busy_at_done", 32'(busy), 32'd0);
          check("sat_mismatch_count", 32'(s_mm_cnt), (e.mm > 16'd15) ? 32'd15 : 32'(e.mm));
          check("sat_fail", 32'(s_fail), 32'(e.fl));
        end
      end
      prev_done = done;
    end
  end

  // Engine model: write pass then read passes, finish released one cycle after start detect
  task automatic engine_run(input logic [17:0] base, input int n, input bit desc, input int rpasses);
    int lat;
    @(negedge Clock);
    BIST_start = 1'b1;
    SRAM_we_n = 1'b1;
    SRAM_address = base;
    @(negedge Clock);
    @(negedge Clock);
    BIST_finish = 1'b0;
    for (int i = 0; i < n; i++) begin
      SRAM_address = desc ? base - 18'(i) : base + 18'(i);
      SRAM_we_n = 1'b0;
      @(negedge Clock);
    end
    for (int p = 0; p < rpasses; p++)
      for (int i = 0; i < n; i++) begin
        SRAM_address = desc ? base - 18'(i) : base + 18'(i);
        SRAM_we_n = 1'b1;
        @(negedge Clock);
      end
    BIST_finish = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge Clock);
      lat++;
      #1;
      if (done) break;
    end
    check("drain_to_done_edges", 32'(lat), 32'd3);
    @(negedge Clock);
    BIST_start = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_mm", 32'(mm_cnt), 0);
    check("rst_rd", 32'(rd_cnt), 0);
    check("rst_sat_all", {s_busy, s_done, s_fail, s_mm_cnt, 26'(s_rd_cnt)}, 0);
    check("rst_sat_regs", 32'(s_first_addr ^ s_last_addr) | 32'(s_first_data), 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    check("idle_done", 32'(done), 0);

    // fault-free: 8 reads
    expect_run(20'd8, 16'd0, 1'b0, 18'h0, 16'h0, 18'h0);
    engine_run(18'h00000, 8, 1'b0, 1);

    // stuck bit 3 at 0x10, two read passes over 0x0C..0x13
    stuck_en = 1;
    expect_run(20'd16, 16'd2, 1'b1, 18'h00010, 16'h0018, 18'h00010);
    engine_run(18'h0000C, 8, 1'b0, 2);
    stuck_en = 0;

    // descending pass 6..0 then 3FFFF..3FFEF: fault at 5 read first, 3FFF0 last
    fa = 18'h00005; fb = 18'h3FFF0; fa_en = 1; fb_en = 1;
    expect_run(20'd24, 16'd2, 1'b1, 18'h00005, 16'h0004, 18'h3FFF0);
    engine_run(18'h00006, 24, 1'b1, 1);
    fb_en = 0;

    // mismatch on the very last read before finish
    fa = 18'h00023;
    expect_run(20'd4, 16'd1, 1'b1, 18'h00023, 16'h0022, 18'h00023);
    engine_run(18'h00020, 4, 1'b0, 1);
    fa_en = 0;

    // restart after a failing run, then reset mid-run
    @(negedge Clock);
    BIST_start = 1'b1;
    @(negedge Clock);
    check("restart_busy", 32'(busy), 1);
    check("restart_done", 32'(done), 0);
    check("restart_fail", 32'(fail), 0);
    check("restart_mm", 32'(mm_cnt), 0);
    check("restart_first_addr", 32'(first_addr), 0);
    @(negedge Clock);
    BIST_finish = 1'b0;
    fault_all = 1;
    for (int i = 0; i < 5; i++) begin
      SRAM_address = 18'h00040 + 18'(i);
      SRAM_we_n = 1'b1;
      @(negedge Clock);
    end
    check("midrun_rd", 32'(rd_cnt), 3);
    check("midrun_mm", 32'(mm_cnt), 3);
    check("midrun_first_data", 32'(first_data), 32'h0000FFBF);
    check("midrun_last_addr", 32'(last_addr), 32'h42);
    #3 Resetn = 1'b0;
    #1;
    check("async_rst_main", {busy, done, fail, 29'(mm_cnt)} | 32'(rd_cnt), 0);
    check("async_rst_regs", 32'(first_addr) | 32'(last_addr) | 32'(first_data), 0);
    check("async_rst_sat", {s_busy, s_done, s_fail, 29'(s_mm_cnt)} | 32'(s_rd_cnt), 0);
    BIST_finish = 1'b1;
    BIST_start = 1'b0;
    fault_all = 0;
    SRAM_we_n = 1'b1;
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    check("post_rst_done", 32'(done), 0);

    // saturation: 20 forced mismatches, CNT_W=4 instance pins at F
    fault_all = 1;
    expect_run(20'd20, 16'd20, 1'b1, 18'h00100, 16'hFEFF, 18'h00113);
    engine_run(18'h00100, 20, 1'b0, 1);
    fault_all = 0;
    check("sat_mm_final", 32'(s_mm_cnt), 32'hF);
    check("sat_fail_final", 32'(s_fail), 1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge Clock);
    check("pending_runs", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_bist_monitor.md
# sram_bist_monitor

Passive result logger that sits directly downstream of the SRAM BIST engine, snooping the same address, write-enable and read-data buses that connect the engine to the SRAM. It re-times each read it observes through the SRAM's fixed two-cycle read latency. It checks the returned word against the address-derived background pattern (data = address[15:0]). It accumulates mismatch statistics (count, first and last failing address/data) for the board display and status LEDs, independently of the engine's own single-bit mismatch flag.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width; pattern = low DATA_W address bits
- CNT_W, 16, mismatch counter width (saturating)

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Resetn  in  1  asynchronous, active-low reset
- BIST_start  in  1  same start level the engine receives; rising edge arms the monitor
- BIST_finish  in  1  engine finish flag
- SRAM_address  in  ADDR_W  address bus driven by the engine
- SRAM_we_n  in  1  engine write enable, active low
- SRAM_read_data  in  DATA_W  SRAM read data
- MON_busy  out  1  monitor armed or draining
- MON_done  out  1  level, results final; held until next arm
- MON_fail  out  1  at least one mismatch logged this run
- MON_mismatch_count  out  CNT_W  mismatches this run, saturates at all-ones
- MON_read_count  out  20  reads checked this run, saturates at 20'hFFFFF
- MON_first_addr  out  ADDR_W  address of first mismatch
- MON_first_data  out  DATA_W  data read at first mismatch
- MON_last_addr  out  ADDR_W  address of most recent mismatch

## Operation
- Start edge: start_buf register; arm = BIST_start & ~start_buf.
- States: M_IDLE, M_ARMED, M_DRAIN.
  - M_IDLE: no checking. On arm: clear all counters and fail regs, flush pipeline, go M_ARMED, MON_busy=1, MON_done=0.
  - M_ARMED: issue = SRAM_we_n & ~BIST_finish. When BIST_finish=1 and the armed cycle count is ≥2, go M_DRAIN.
  - The ≥2 guard exists because the engine drops finish one cycle after its own start detection.
  - M_DRAIN: no new issues. When both pipeline valids are 0, go M_IDLE, MON_busy=0, MON_done=1.
- Arm in any state restarts: clear and go M_ARMED. Arm wins over drain completion in the same cycle.
- Read pipeline: stage1 {v1,a1} <= {issue, SRAM_address}; stage2 {v2,a2} <= {v1,a1}.
  - When v2=1, compare SRAM_read_data against a2[DATA_W-1:0].
- On compare:
  - MON_read_count +1 (saturating).
  - On mismatch: MON_mismatch_count +1 (saturating); MON_last_addr <= a2.
  - On the first mismatch only: MON_first_addr <= a2, MON_first_data <= SRAM_read_data, MON_fail <= 1.
- Write cycles (SRAM_we_n=0) are never checked, nor is any cycle with BIST_finish=1.
- Address direction (up or down) is irrelevant: the expected value comes only from the delayed address.

## Timing
- Reset: state M_IDLE; all outputs 0; v1=v2=0; start_buf=0.
- Read issued (sampled) at edge N. Data sampled and compared at edge N+2. Counters and fail regs are visible after edge N+2, so the read-to-flag latency is 2 cycles.
- Back-to-back reads every cycle are supported: full throughput, no stalls.
- MON_done rises at most 2 cycles after the M_DRAIN entry edge.
- Counter saturation: at all-ones, a further increment holds the value, and MON_fail stays 1.
- Reset mid-run: immediate clear to the reset values. MON_done stays 0 until a complete run.
- BIST_start held high: only one arm, no re-arm until it drops and rises again.

## Test plan
- Fault-free SRAM model (2-cycle latency), full BIST run:
  - MON_done=1 and MON_fail=0, MON_mismatch_count=0.
  - MON_read_count equals the number of read cycles the engine issued while finish=0.
- Stuck bit: SRAM model forces data bit 3 to 1 at address 18'h00010:
  - MON_mismatch_count = number of reads of that address.
  - MON_first_addr=18'h00010, MON_first_data=16'h0018.
- Two faults, at 18'h00005 then 18'h3FFF0, during a descending pass:
  - MON_first_addr=18'h00005.
  - MON_last_addr is whichever fault is read last in time.
  - Count=2 per pass.
- Drain: a mismatch on the read issued in the last cycle before finish rises is still counted; MON_done rises ≤2 cycles after finish.
- Restart: after a failing run, a new start edge clears everything (count 0, MON_fail=0, done=0). Reset asserted mid-run zeroes all outputs asynchronously.
- Saturation: with CNT_W=4 and 20 forced mismatches, MON_mismatch_count=4'hF and MON_fail=1.
